// File: rtl/regbank_pkg.sv
// Shared defaults and helpers for the multiport register bank.
package regbank_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NRD   = 2;

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int DEF_ADDR_W = addr_width(DEF_DEPTH);

  typedef logic [DEF_NRD*DEF_ADDR_W-1:0] rd_addr_vec_t;
  typedef logic [DEF_NRD*DEF_WIDTH-1:0]  rd_data_vec_t;
endpackage

// File: rtl/regbank_multiport_onehot_decoder.sv
// One-hot decoder: turns a binary address into N_OUT strobes, all low when en=0.
module onehot_decoder #(
  parameter  int N_OUT = 8,
  localparam int AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [N_OUT-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end
endmodule

// File: rtl/regbank_multiport.sv
// Register bank with one write port, NRD registered read ports, optional
// write-to-read bypass, optional hardwired zero register and bulk clear.
module regbank_multiport
  import regbank_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int NRD       = DEF_NRD,
  parameter  int BYPASS    = 1,
  parameter  int ZERO_REG0 = 0,
  localparam int ADDR_W    = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD-1:0]        rd_valid
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regbank_multiport: DEPTH must be a power of 2 and >= 2");
  end

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            dec;
  logic [DEPTH-1:0]            we;
  logic                        wr_go;

  assign wr_go = wr_en && !clr;

  onehot_decoder #(.N_OUT(DEPTH)) u_dec (
    .en     (wr_go),
    .addr   (wr_addr),
    .onehot (dec)
  );

  // Register 0 never takes a strobe when it is hardwired to zero.
  always_comb begin
    we = dec;
    if (ZERO_REG0 != 0) we[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs <= '0;
    end else if (clr) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (we[k]) regs[k] <= wr_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  rnext;
    logic              hit;
    logic              zero;

    assign raddr = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero  = (ZERO_REG0 != 0) && (raddr == '0);
    // wr_go already excludes clr, so a read during clear sees pre-clear data.
    assign hit   = (BYPASS != 0) && wr_go && (raddr == wr_addr);

    always_comb begin
      rnext = regs[raddr];
      if (hit)  rnext = wr_data;
      if (zero) rnext = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd_data[i*WIDTH +: WIDTH] <= '0;
        rd_valid[i]               <= 1'b0;
      end else begin
        rd_valid[i] <= rd_en[i];
        if (rd_en[i]) rd_data[i*WIDTH +: WIDTH] <= rnext;
      end
    end
  end
endmodule

// File: tb/tb_regbank_multiport.sv
// Bench for regbank_multiport: two configurations (bypass / no-bypass+zero-reg)
// driven in lockstep and compared against an array-based reference model.
module tb_regbank_multiport;
  import regbank_pkg::*;

  logic         clk;
  logic         resetn;
  logic         clr;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [1:0]   rd_en;
  rd_addr_vec_t rd_addr;
  rd_data_vec_t rd_data_a, rd_data_b;
  logic [1:0]   rd_valid_a, rd_valid_b;

  regbank_multiport #(.BYPASS(1), .ZERO_REG0(0)) dut_a (
    .clk(clk), .resetn(resetn), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );

  regbank_multiport #(.BYPASS(0), .ZERO_REG0(1)) dut_b (
    .clk(clk), .resetn(resetn), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference: register contents and expected outputs for each configuration.
  logic [7:0]  ma[8];
  logic [7:0]  mb[8];
  logic [15:0] ea, eb;
  logic [1:0]  ev;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      ma[k] = 8'h00;
      mb[k] = 8'h00;
    end
    ea = '0;
    eb = '0;
    ev = '0;
  endtask

  function automatic logic [7:0] pred(input bit byp, input bit z,
                                      input logic [7:0] mv, input int a);
    if (z && a == 0) return 8'h00;
    if (byp && wr_en && !clr && a == int'(wr_addr)) return wr_data;
    return mv;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data_a"},  rd_data_a,          ea);
    chk({tag, ".data_b"},  rd_data_b,          eb);
    chk({tag, ".valid_a"}, {14'd0, rd_valid_a}, {14'd0, ev});
    chk({tag, ".valid_b"}, {14'd0, rd_valid_b}, {14'd0, ev});
  endtask

  // One clock: predict from pre-edge inputs and state, advance, then compare.
  task automatic step(input string tag);
    logic [15:0] na, nb;
    int a;
    na = ea;
    nb = eb;
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        a = int'(rd_addr[p*3 +: 3]);
        na[p*8 +: 8] = pred(1'b1, 1'b0, ma[a], a);
        nb[p*8 +: 8] = pred(1'b0, 1'b1, mb[a], a);
      end
    end
    @(posedge clk);
    if (clr) begin
      for (int k = 0; k < 8; k++) begin
        ma[k] = 8'h00;
        mb[k] = 8'h00;
      end
    end else if (wr_en) begin
      ma[wr_addr] = wr_data;
      if (wr_addr != 3'd0) mb[wr_addr] = wr_data;
    end
    ea = na;
    eb = nb;
    ev = rd_en;
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic c, input logic [1:0] re,
                       input logic [2:0] ra0, input logic [2:0] ra1);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    clr     = c;
    rd_en   = re;
    rd_addr = {ra1, ra0};
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    model_reset();
    #2;
    check_all("reset_state");
    @(posedge clk);
    #1 resetn = 1'b1;

    // Preload so a read returns non-zero data before the mid-cycle reset.
    drive(1, 3'd4, 8'h9C, 0, 2'b00, 0, 0);
    step("pre_wr");
    drive(0, 0, 0, 0, 2'b11, 3'd4, 3'd4);
    step("pre_rd");
    #3 resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0);

    for (int k = 0; k < 8; k += 2) begin
      drive(0, 0, 0, 0, 2'b11, 3'(k), 3'(k + 1));
      step("post_reset_rd");
    end

    for (int k = 0; k < 8; k++) begin
      drive(1, 3'(k), 8'(8'h10 + k), 0, 2'b00, 0, 0);
      step("wr_all");
    end
    drive(0, 0, 0, 0, 2'b11, 3'd3, 3'd6);
    step("rd_3_6");
    chk("rd_p0_0x13", rd_data_a[7:0],  16'h13);
    chk("rd_p1_0x16", rd_data_a[15:8], 16'h16);

    drive(0, 0, 0, 0, 2'b00, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step("hold");
      chk("hold_0x13", rd_data_a[7:0], 16'h13);
    end

    drive(1, 3'd5, 8'hAA, 0, 2'b00, 0, 0);
    step("coll_pre");
    drive(1, 3'd5, 8'h55, 0, 2'b01, 3'd5, 3'd0);
    step("collide");
    chk("byp_new",   rd_data_a[7:0], 16'h55);
    chk("nobyp_old", rd_data_b[7:0], 16'hAA);
    drive(0, 0, 0, 0, 2'b01, 3'd5, 3'd0);
    step("coll_after");
    chk("nobyp_after", rd_data_b[7:0], 16'h55);

    drive(1, 3'd0, 8'hFF, 0, 2'b11, 3'd0, 3'd0);
    step("zero_wr");
    chk("zero_same", rd_data_b, 16'h0000);
    drive(0, 0, 0, 0, 2'b11, 3'd0, 3'd0);
    step("zero_next");
    chk("zero_next", rd_data_b, 16'h0000);

    drive(1, 3'd2, 8'h77, 1, 2'b01, 3'd2, 3'd0);
    step("clr_prio");
    chk("clr_pre_a", rd_data_a[7:0], 16'h12);
    chk("clr_pre_b", rd_data_b[7:0], 16'h12);
    drive(0, 0, 0, 0, 2'b11, 3'd2, 3'd7);
    step("clr_after");
    chk("clr_zero", rd_data_a[7:0], 16'h00);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) rd_addr[5:3] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[2:0] = wr_addr;
      step("rand");
      if (i == 200) begin
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all("rand_reset");
        @(posedge clk);
        #1 resetn = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
